// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: samples one ALU memory request, runs it on a req/gnt/rvalid
// data bus and returns extended load data. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int unsigned Xlen      = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned RegAddrW  = 5,
  parameter int unsigned Timeout   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [AddrWidth-1:0] mem_addr,
  input  logic [Xlen-1:0]      mem_data,
  input  logic [2:0]           mem_op_type,
  input  logic [RegAddrW-1:0]  mem_rd_addr,
  output logic                 stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [AddrWidth-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [Xlen-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [Xlen-1:0]      dmem_rdata,
  output logic                 reg_dv,
  output logic [RegAddrW-1:0]  reg_addr,
  output logic [Xlen-1:0]      reg_data,
  output logic                 illegal,
  output logic                 misaligned,
  output logic                 bus_err
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          op_q;
  logic [1:0]          addr_lo_q;
  logic [RegAddrW-1:0] rd_q;

  logic            load_ok, store_ok, misalign, timeout_hit;
  logic [3:0]      st_be;
  logic [Xlen-1:0] st_wdata, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    load_ok  = mem_op_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    store_ok = mem_op_type inside {3'b000, 3'b001, 3'b010};
    misalign = ((mem_op_type[1:0] == 2'b01) && mem_addr[0]) ||
               ((mem_op_type[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));

    case (mem_op_type[1:0])
      2'b00: begin
        st_be    = 4'b0001 << mem_addr[1:0];
        st_wdata = {4{mem_data[7:0]}};
      end
      2'b01: begin
        st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = mem_data;
      end
    endcase

    ld_byte = dmem_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (op_q)
      3'b000:  ld_data = {{(Xlen-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(Xlen-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(Xlen-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(Xlen-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase

    // A zero Timeout never matches, so the wait is unbounded.
    timeout_hit = (Timeout != 0) && (cnt_q == CntW'(Timeout - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      addr_lo_q  <= '0;
      rd_q       <= '0;
      stall      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      reg_dv     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      reg_dv     <= 1'b0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_read || mem_write) begin
            // Write wins when both strobes are raised.
            if (mem_write ? !store_ok : !load_ok) begin
              illegal <= 1'b1;
            end else if (TrapEn && misalign) begin
              misaligned <= 1'b1;
            end else begin
              state_q    <= StReq;
              cnt_q      <= '0;
              stall      <= 1'b1;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {mem_addr[AddrWidth-1:2], 2'b00};
              dmem_be    <= mem_write ? st_be : 4'b1111;
              dmem_wdata <= mem_write ? st_wdata : '0;
              op_q       <= mem_op_type;
              addr_lo_q  <= mem_addr[1:0];
              rd_q       <= mem_rd_addr;
            end
          end
        end
        StReq: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            cnt_q    <= '0;
            if (dmem_we) begin
              state_q <= StIdle;
              stall   <= 1'b0;
            end else begin
              state_q <= StWait;
            end
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            dmem_req <= 1'b0;
            state_q  <= StIdle;
            stall    <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWait: begin
          if (dmem_rvalid) begin
            // x0 loads still hit the bus but never write back.
            if (rd_q != '0) begin
              reg_dv   <= 1'b1;
              reg_addr <= rd_q;
              reg_data <= ld_data;
            end
            state_q <= StIdle;
            stall   <= 1'b0;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            state_q <= StIdle;
            stall   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: load write-backs are predicted at stimulus time and
// popped by a monitor when reg_dv fires; bus fields are checked against a lane model.
module tb_lsu_mem_stage;

  localparam int unsigned Tmo = 4;

  logic        clk, rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  mem_op_type;
  logic [4:0]  mem_rd_addr;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, reg_data;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic        reg_dv, illegal, misaligned, bus_err;
  logic [4:0]  reg_addr;

  lsu_mem_stage #(.Timeout(Tmo)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_op_type (mem_op_type),
    .mem_rd_addr (mem_rd_addr),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .reg_dv      (reg_dv),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .illegal     (illegal),
    .misaligned  (misaligned),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] op,
                                        input logic [1:0] lo);
    if (!we) return 4'b1111;
    case (op)
      3'b000:  return 4'b0001 << lo;
      3'b001:  return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * lo));
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reg_dv) begin
      if (exp_q.size() == 0) begin
        check_eq("dv_unexpected", 32'(reg_dv), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check_eq("wb_rd", 32'(reg_addr), 32'(e.rd));
        check_eq("wb_data", reg_data, e.data);
      end
    end
  end

  task automatic clear_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] op, input logic [4:0] rd);
    @(negedge clk);
    mem_read    = rd_en;
    mem_write   = wr_en;
    mem_addr    = addr;
    mem_data    = data;
    mem_op_type = op;
    mem_rd_addr = rd;
    @(negedge clk);
    clear_inputs();
  endtask

  // Full transaction: request held for gnt_dly extra cycles, zero-wait rvalid for loads.
  task automatic xact(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                      input logic [31:0] data, input logic [2:0] op, input logic [4:0] rd,
                      input int gnt_dly, input logic [31:0] rdata);
    logic we;
    we = wr_en;
    drive(rd_en, wr_en, addr, data, op, rd);
    for (int i = 0; i <= gnt_dly; i++) begin
      check_eq("req", 32'(dmem_req), 32'd1);
      check_eq("stall", 32'(stall), 32'd1);
      check_eq("we", 32'(dmem_we), 32'(we));
      check_eq("addr", dmem_addr, {addr[31:2], 2'b00});
      check_eq("be", 32'(dmem_be), 32'(exp_be(we, op, addr[1:0])));
      if (we) check_eq("wdata", dmem_wdata, exp_wdata(op, data));
      dmem_gnt = (i == gnt_dly);
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    check_eq("req_drop", 32'(dmem_req), 32'd0);
    if (we) begin
      check_eq("st_idle", 32'(stall), 32'd0);
      check_eq("st_no_dv", 32'(reg_dv), 32'd0);
    end else begin
      check_eq("wait_stall", 32'(stall), 32'd1);
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      if (rd != 5'd0) exp_q.push_back('{rd: rd, data: exp_load(op, addr[1:0], rdata)});
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check_eq("ld_dv", 32'(reg_dv), 32'(rd != 5'd0));
      check_eq("ld_idle", 32'(stall), 32'd0);
      @(negedge clk);
      check_eq("dv_pulse", 32'(reg_dv), 32'd0);
    end
  endtask

  task automatic illegal_op(input logic rd_en, input logic wr_en, input logic [2:0] op);
    drive(rd_en, wr_en, 32'h10, 32'h0, op, 5'd1);
    check_eq("ill_pulse", 32'(illegal), 32'd1);
    check_eq("ill_no_req", 32'(dmem_req), 32'd0);
    check_eq("ill_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check_eq("ill_clear", 32'(illegal), 32'd0);
    check_eq("ill_no_req2", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    mem_op_type = '0;
    mem_rd_addr = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_bus", {dmem_addr[27:0], dmem_be} | dmem_wdata, 32'd0);
    check_eq("rst_wb", 32'(reg_dv) | 32'(reg_addr) | reg_data, 32'd0);
    check_eq("rst_flags", {29'd0, illegal, misaligned, bus_err}, 32'd0);
    rst_n = 1'b1;

    // Stores: byte lanes, halfword lanes, word; write wins over read.
    xact(1'b0, 1'b1, 32'h1003, 32'h000000A5, 3'b000, 5'd0, 2, '0);
    xact(1'b0, 1'b1, 32'h2002, 32'h1234BEEF, 3'b001, 5'd0, 0, '0);
    xact(1'b0, 1'b1, 32'h2000, 32'h1234BEEF, 3'b001, 5'd0, 1, '0);
    xact(1'b1, 1'b1, 32'h0040, 32'hDEADBEEF, 3'b010, 5'd3, 0, '0);

    // Loads: sign/zero extension across lanes.
    xact(1'b1, 1'b0, 32'h2001, 32'h0, 3'b000, 5'd7, 0, 32'h00C38000);
    xact(1'b1, 1'b0, 32'h2001, 32'h0, 3'b100, 5'd7, 0, 32'h00C38000);
    xact(1'b1, 1'b0, 32'h2003, 32'h0, 3'b000, 5'd8, 1, 32'h7F123456);
    xact(1'b1, 1'b0, 32'h2002, 32'h0, 3'b001, 5'd9, 0, 32'h8001FFFF);
    xact(1'b1, 1'b0, 32'h2002, 32'h0, 3'b101, 5'd9, 0, 32'h8001FFFF);
    xact(1'b1, 1'b0, 32'h2000, 32'h0, 3'b001, 5'd10, 0, 32'h8001FFFF);
    xact(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 5'd31, 2, 32'h8001FFFF);
    xact(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 5'd0, 0, 32'hCAFEF00D);

    // Unsupported funct3 codes.
    illegal_op(1'b1, 1'b0, 3'b011);
    illegal_op(1'b1, 1'b0, 3'b110);
    illegal_op(1'b1, 1'b1, 3'b100);

    // Timeout while waiting for gnt.
    drive(1'b1, 1'b0, 32'h5000, 32'h0, 3'b010, 5'd4);
    for (int i = 0; i < Tmo; i++) begin
      check_eq("tmo_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
    end
    check_eq("tmo_req_err", 32'(bus_err), 32'd1);
    check_eq("tmo_req_drop", 32'(dmem_req), 32'd0);
    check_eq("tmo_req_idle", 32'(stall), 32'd0);
    @(negedge clk);
    check_eq("tmo_req_pulse", 32'(bus_err), 32'd0);

    // Timeout while waiting for rvalid.
    drive(1'b1, 1'b0, 32'h5004, 32'h0, 3'b010, 5'd4);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    for (int i = 0; i < Tmo; i++) begin
      check_eq("tmo_wait_stall", 32'(stall), 32'd1);
      check_eq("tmo_wait_noerr", 32'(bus_err), 32'd0);
      @(negedge clk);
    end
    check_eq("tmo_wait_err", 32'(bus_err), 32'd1);
    check_eq("tmo_wait_idle", 32'(stall), 32'd0);

    // Reset during REQ drops the request immediately.
    drive(1'b1, 1'b0, 32'h6000, 32'h0, 3'b010, 5'd5);
    check_eq("pre_rst_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_drop", 32'(dmem_req), 32'd0);
    check_eq("rst_req_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT; a late rvalid must not write back.
    drive(1'b1, 1'b0, 32'h6004, 32'h0, 3'b010, 5'd6);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_eq("pre_rst_wait", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_wait_stall", 32'(stall), 32'd0);
    check_eq("rst_wait_out", 32'(dmem_req) | 32'(dmem_be) | dmem_addr | 32'(reg_dv), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11111111;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_eq("late_rvalid_dv", 32'(reg_dv), 32'd0);
    check_eq("late_rvalid_idle", 32'(stall), 32'd0);

    // Misaligned word access.
`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 32'h3002, 32'h0, 3'b010, 5'd9);
    check_eq("mis_pulse", 32'(misaligned), 32'd1);
    check_eq("mis_no_req", 32'(dmem_req), 32'd0);
    check_eq("mis_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check_eq("mis_clear", 32'(misaligned), 32'd0);
`else
    xact(1'b1, 1'b0, 32'h3002, 32'h0, 3'b010, 5'd9, 0, 32'h12345678);
    xact(1'b1, 1'b0, 32'h3003, 32'h0, 3'b001, 5'd11, 0, 32'hA5F00000);
    check_eq("mis_tied", 32'(misaligned), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Data-memory responder for the ALU's memory-operation output; sits between the execute stage and the data-memory bus.
- Accepts one load/store request (address, store data, funct3 op type, destination register), drives a req/gnt/rvalid data bus with byte enables, and returns sign/zero-extended load data as a register write-back.
- Stalls upstream while a transaction is outstanding.

Parameters:
- cXLEN, 32, data width; only 32 is supported.
- cAddrWidth, 32, byte address width.
- cRegAddrW, 5, register index width.
- cTimeout, 255, max cycles waiting in REQ or WAIT before a bus error is raised; 0 disables the timeout.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous, active-low reset.
- iMemRead  in  1  load request from ALU.
- iMemWrite  in  1  store request from ALU.
- iMemAddr  in  cAddrWidth  effective byte address.
- iMemData  in  cXLEN  store data (rs2).
- iMemOpType  in  3  funct3.
- iMemRdAddr  in  cRegAddrW  load destination register.
- oStall  out  1  high while not IDLE.
- oDmemReq  out  1  bus request.
- oDmemWe  out  1  1 = write.
- oDmemAddr  out  cAddrWidth  word-aligned address ({addr[31:2],2'b00}).
- oDmemBe  out  4  byte enables.
- oDmemWdata  out  cXLEN  lane-replicated store data.
- iDmemGnt  in  1  request accepted.
- iDmemRvalid  in  1  read data valid.
- iDmemRdata  in  cXLEN  read word.
- oRegDv  out  1  one-cycle write-back strobe.
- oRegAddr  out  cRegAddrW  write-back register.
- oRegData  out  cXLEN  extended load data.
- oIllegal  out  1  one-cycle pulse for an unsupported funct3.
- oMisaligned  out  1  one-cycle pulse for a misaligned access (see Optional Feature).
- oBusErr  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (iRst low, async): state IDLE; every output 0; timeout counter 0; captured request cleared. A reset mid-transaction drops oDmemReq immediately and any late rvalid is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Inputs are sampled only here, and only when iMemRead|iMemWrite.
  - If both read and write are high, the write wins and the read is discarded.
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3: oIllegal pulses the next cycle, no bus access, stay IDLE.
  - Legal request: register addr/data/op/rd, go to REQ. oDmemReq rises the cycle after sampling.
- REQ:
  - oDmemReq, oDmemWe, oDmemAddr, oDmemBe and oDmemWdata are held stable until the iDmemGnt cycle.
  - Store granted: go to IDLE.
  - Load granted: go to WAIT.
  - oDmemReq drops the cycle after gnt.
- WAIT:
  - On iDmemRvalid: oRegDv=1 for exactly one cycle with oRegAddr=rd and oRegData=extracted value, then IDLE.
  - rvalid arriving in the same cycle as gnt is not legal on this bus; an rvalid outside WAIT is ignored.
- Store lanes:
  - SB: Be = 4'b0001<<addr[1:0]; Wdata = {4{data[7:0]}}.
  - SH: Be = addr[1] ? 4'b1100 : 4'b0011; Wdata = {2{data[15:0]}}.
  - SW: Be = 4'b1111; Wdata = data.
  - For loads, oDmemBe = 4'b1111.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- rd = 0 loads: the bus access is performed but oRegDv stays 0.
- Timeout:
  - The counter runs in REQ and WAIT and clears on each state change.
  - Reaching cTimeout: oBusErr pulses, oDmemReq drops, go to IDLE, no write-back.
- Latency, zero-wait bus: store 2 cycles sample→IDLE; load 3 cycles sample→oRegDv.
- oStall is registered: oStall = (state != IDLE).

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1 or word with addr[1:0]≠0 pulses oMisaligned the cycle after sampling.
  - No bus access is made; state stays IDLE.
- Undefined:
  - oMisaligned is tied 0.
  - Misaligned halfword uses addr[1] lanes (addr[0] ignored); misaligned word uses the aligned word (addr[1:0] ignored).

Test Plan:
- Store SB with addr=0x1003, data=0xA5, gnt after 2 cycles → oDmemAddr=0x1000, Be=1000, Wdata=0xA5A5A5A5; oStall high 3 cycles; no oRegDv.
- Load LB with addr=0x2001, rd=7, rdata=0x00C38000, zero-wait → oRegDv 3 cycles after sampling, oRegAddr=7, oRegData=0xFFFFFF80. Repeat with LBU → 0x00000080.
- LH with addr=0x2002, rdata=0x8001FFFF → 0xFFFF8001. LHU → 0x00008001. LW → 0x8001FFFF.
- funct3=011 with read=1 → oIllegal pulses once, oDmemReq never asserts, oStall stays 0.
- Load with cTimeout=4 and no gnt → oBusErr after 4 REQ cycles, oDmemReq drops, return to IDLE. Assert iRst mid-WAIT → all outputs 0 immediately; a following rvalid produces no oRegDv.
- LW with addr=0x3002: with LSU_MISALIGN_TRAP_EN → oMisaligned pulse and no request; without it → request to 0x3000 and normal write-back.
